aes_key_expander: RTL

- On-the-fly AES-128 key schedule. Sits directly upstream of the round datapath and drives its key_i input.
- Latches a 128-bit cipher key, then on each round request produces the next round key (rounds 0..10), one per request.
- Stores only the current round key, not all 11 keys, to keep area low in the feedback (iterative) architecture.

---
 rtl/aes_key_expander_pkg.sv | 40 ++++
 rtl/aes_sub_word.sv | 13 +
 rtl/aes_key_expander.sv | 75 +++++++
 3 files changed

// File: rtl/aes_key_expander_pkg.sv
// Shared constants, state encoding and S-box table for the AES-128 key schedule.
package aes_key_expander_pkg;

    localparam int unsigned AES_WIDTH   = 128;
    localparam int unsigned AES_NR      = 10;
    localparam int unsigned IDX_W       = 4;
    localparam logic [7:0]  RCON_INIT   = 8'h01;
    localparam logic [7:0]  GF_POLY_RED = 8'h1b;

    typedef enum logic {
        IDLE  = 1'b0,
        READY = 1'b1
    } ks_state_e;

    // Forward S-box, shared with the round datapath's byte substitution.
    localparam logic [7:0] SBOX_TABLE [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x in GF(2^8), reducing by the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] rc);
        return {rc[6:0], 1'b0} ^ (rc[7] ? GF_POLY_RED : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// 32-bit SubWord: four parallel byte S-box lookups.
module aes_sub_word
    import aes_key_expander_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub
);

    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign sub[8*i +: 8] = SBOX_TABLE[word[8*i +: 8]];
    end

endmodule

// File: rtl/aes_key_expander.sv
// On-the-fly AES-128 key schedule holding only the current round key.
module aes_key_expander
    import aes_key_expander_pkg::*;
#(
    parameter int unsigned WIDTH = AES_WIDTH,
    parameter int unsigned NR    = AES_NR
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             key_load_i,
    input  logic [WIDTH-1:0] key_i,
    input  logic             round_req_i,
    output logic [WIDTH-1:0] round_key_o,
    output logic             round_key_valid_o,
    output logic [IDX_W-1:0] round_idx_o,
    output logic             busy_o,
    output logic             done_o
);

    ks_state_e   state;
    logic [7:0]  rcon;
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w3, sub_w3, t_word;
    logic [31:0] n0, n1, n2, n3;

    // Next round key derived combinationally from the stored key.
    assign {w0, w1, w2, w3} = round_key_o;
    assign rot_w3 = {w3[23:0], w3[31:24]};

    aes_sub_word u_sub_word (
        .word (rot_w3),
        .sub  (sub_w3)
    );

    assign t_word = sub_w3 ^ {rcon, 24'h000000};
    assign n0     = w0 ^ t_word;
    assign n1     = w1 ^ n0;
    assign n2     = w2 ^ n1;
    assign n3     = w3 ^ n2;

    // Schedule FSM: load has priority over request; request past last round ends it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state             <= IDLE;
            round_key_o       <= '0;
            round_key_valid_o <= 1'b0;
            round_idx_o       <= '0;
            busy_o            <= 1'b0;
            done_o            <= 1'b0;
            rcon              <= RCON_INIT;
        end else begin
            done_o <= 1'b0;
            if (key_load_i) begin
                state             <= READY;
                round_key_o       <= key_i;
                round_key_valid_o <= 1'b1;
                round_idx_o       <= '0;
                busy_o            <= 1'b1;
                rcon              <= RCON_INIT;
            end else if (round_req_i && state == READY) begin
                if (round_idx_o < IDX_W'(NR)) begin
                    round_key_o <= {n0, n1, n2, n3};
                    round_idx_o <= round_idx_o + IDX_W'(1);
                    rcon        <= xtime(rcon);
                end else begin
                    state             <= IDLE;
                    round_key_valid_o <= 1'b0;
                    busy_o            <= 1'b0;
                    done_o            <= 1'b1;
                end
            end
        end
    end

endmodule
